branch_resolve: RTL and testbench

- ID/EX-boundary branch resolver; producer side of the branch-decision interface.
- Decodes the ID-stage instruction and generates the kind[1:0] / cond pair that the downstream condition gate consumes.
- Computes the redirect target and sequences the IF/ID flush window after a taken branch.
- No delay slot. Redirect is resolved one cycle after the instruction is accepted.

---
 rtl/branch_resolve.sv | 233 +++++++++++++++++++++++
 tb/tb_branch_resolve.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// ID/EX branch resolver: decodes branches/jumps, registers kind/cond/target, sequences the IF/ID flush.
// Optional BRANCH_STATS_EN adds br_total / br_taken event counters.
module branch_resolve #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] PC_RESET     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_pc_plus4,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   output logic [1:0]  kind,
   output logic        cond,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        busy
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] br_total,
   output logic [31:0] br_taken
`endif
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] EXEC  = 2'b01;
   localparam logic [1:0] FLUSH = 2'b10;
   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [1:0]  state_r, state_s;
   logic [1:0]  kind_r, kind_s;
   logic        cond_r, cond_s;
   logic [31:0] pc_r, pc_s;
   logic        flush_r, flush_s;
   logic        busy_r, busy_s;
   logic [2:0]  cnt_r, cnt_s;

   logic [5:0]  opcode_s;
   logic [4:0]  rt_fld_s;
   logic [5:0]  funct_s;
   logic        rs_zero_s;
   logic [31:0] br_target_s;
   logic [1:0]  dec_kind_s;
   logic        dec_cond_s;
   logic [31:0] dec_target_s;
   logic        dec_redirect_s;

   assign opcode_s    = id_instr[31:26];
   assign rt_fld_s    = id_instr[20:16];
   assign funct_s     = id_instr[5:0];
   assign rs_zero_s   = (id_rs_data == 32'h0000_0000);
   assign br_target_s = id_pc_plus4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};

   // Instruction decode: branch kind, condition and target of the ID instruction
   always_comb begin
      dec_kind_s   = 2'b00;
      dec_cond_s   = 1'b0;
      dec_target_s = br_target_s;
      case (opcode_s)
         6'b000100: begin
            dec_kind_s = 2'b10;
            dec_cond_s = (id_rs_data == id_rt_data);
         end
         6'b000101: begin
            dec_kind_s = 2'b10;
            dec_cond_s = (id_rs_data != id_rt_data);
         end
         6'b000110: begin
            dec_kind_s = 2'b10;
            dec_cond_s = id_rs_data[31] | rs_zero_s;
         end
         6'b000111: begin
            dec_kind_s = 2'b10;
            dec_cond_s = ~id_rs_data[31] & ~rs_zero_s;
         end
         6'b000001: begin
            case (rt_fld_s)
               5'b00000: begin
                  dec_kind_s = 2'b10;
                  dec_cond_s = id_rs_data[31];
               end
               5'b00001: begin
                  dec_kind_s = 2'b10;
                  dec_cond_s = ~id_rs_data[31];
               end
               default: begin
                  dec_kind_s = 2'b00;
                  dec_cond_s = 1'b0;
               end
            endcase
         end
         6'b000010, 6'b000011: begin
            dec_kind_s   = 2'b11;
            dec_target_s = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
         end
         6'b000000: begin
            if (funct_s == 6'b001000) begin
               dec_kind_s   = 2'b11;
               dec_target_s = id_rs_data;
            end else begin
               dec_kind_s = 2'b00;
            end
         end
         default: begin
            dec_kind_s = 2'b00;
            dec_cond_s = 1'b0;
         end
      endcase
   end

   assign dec_redirect_s = dec_kind_s[1] & (dec_kind_s[0] | dec_cond_s);
   assign redirect       = kind_r[1] & (kind_r[0] | cond_r);

   // Next-state logic: accept in IDLE or not-taken EXEC, otherwise run the flush window
   always_comb begin
      state_s = state_r;
      kind_s  = kind_r;
      cond_s  = cond_r;
      pc_s    = pc_r;
      flush_s = flush_r;
      busy_s  = busy_r;
      cnt_s   = cnt_r;
      if (!stall) begin
         case (state_r)
            IDLE, EXEC: begin
               if ((state_r == EXEC) && redirect) begin
                  kind_s = 2'b00;
                  cond_s = 1'b0;
                  if (FLUSH_CYCLES > 1) begin
                     state_s = FLUSH;
                     flush_s = 1'b1;
                     busy_s  = 1'b1;
                     cnt_s   = CNT_LOAD;
                  end else begin
                     state_s = IDLE;
                     flush_s = 1'b0;
                     busy_s  = 1'b0;
                     cnt_s   = 3'd0;
                  end
               end else if (id_valid) begin
                  state_s = EXEC;
                  kind_s  = dec_kind_s;
                  cond_s  = dec_cond_s;
                  pc_s    = dec_target_s;
                  flush_s = dec_redirect_s;
                  busy_s  = dec_redirect_s;
               end else begin
                  state_s = IDLE;
                  kind_s  = 2'b00;
                  cond_s  = 1'b0;
                  flush_s = 1'b0;
                  busy_s  = 1'b0;
               end
            end
            FLUSH: begin
               // id_valid is deliberately ignored here: those instructions are squashed
               if (cnt_r <= 3'd1) begin
                  state_s = IDLE;
                  flush_s = 1'b0;
                  busy_s  = 1'b0;
                  cnt_s   = 3'd0;
               end else begin
                  cnt_s = cnt_r - 3'd1;
               end
            end
            default: begin
               state_s = IDLE;
               kind_s  = 2'b00;
               cond_s  = 1'b0;
               flush_s = 1'b0;
               busy_s  = 1'b0;
               cnt_s   = 3'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         kind_r  <= 2'b00;
         cond_r  <= 1'b0;
         pc_r    <= PC_RESET;
         flush_r <= 1'b0;
         busy_r  <= 1'b0;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_s;
         kind_r  <= kind_s;
         cond_r  <= cond_s;
         pc_r    <= pc_s;
         flush_r <= flush_s;
         busy_r  <= busy_s;
         cnt_r   <= cnt_s;
      end
   end

   assign kind        = kind_r;
   assign cond        = cond_r;
   assign redirect_pc = pc_r;
   assign flush       = flush_r;
   assign busy        = busy_r;

`ifdef BRANCH_STATS_EN
   logic [31:0] br_total_r;
   logic [31:0] br_taken_r;

   // Branch statistics, counted once per non-stalled EXEC cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         br_total_r <= 32'd0;
         br_taken_r <= 32'd0;
      end else if (!stall && (state_r == EXEC)) begin
         if (kind_r != 2'b00) begin
            br_total_r <= br_total_r + 32'd1;
         end
         if (redirect) begin
            br_taken_r <= br_taken_r + 32'd1;
         end
      end
   end

   assign br_total = br_total_r;
   assign br_taken = br_taken_r;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: decode vector table with a scoreboard queue,
// plus hand-written flush, back-to-back, stall and (optional) statistics sequences.
module tb_branch_resolve;

   localparam int FC = 2;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pc4;
      logic [1:0]  kind;
      logic        cond;
      logic        chk_pc;
      logic [31:0] pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [1:0]  kind;
   logic        cond;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        busy;
`ifdef BRANCH_STATS_EN
   logic [31:0] br_total;
   logic [31:0] br_taken;
`endif

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vecs[19];
   vec_t sb_q[$];

   branch_resolve #(.FLUSH_CYCLES(FC), .PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid),
      .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .kind(kind), .cond(cond), .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush), .busy(busy)
`ifdef BRANCH_STATS_EN
      , .br_total(br_total), .br_taken(br_taken)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] pc4, input logic [1:0] k, input logic c,
                               input logic chk, input logic [31:0] pc);
      vec_t v;
      v.instr = instr; v.rs = rs; v.rt = rt; v.pc4 = pc4;
      v.kind = k; v.cond = c; v.chk_pc = chk; v.pc = pc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      id_valid    = 1'b1;
      id_instr    = v.instr;
      id_rs_data  = v.rs;
      id_rt_data  = v.rt;
      id_pc_plus4 = v.pc4;
   endtask

   // Single isolated instruction: accept, compare against scoreboard, then measure the flush window
   task automatic apply_vec(input int i);
      vec_t e;
      logic exp_red;
      int   fcnt;
      drive(vecs[i]);
      sb_q.push_back(vecs[i]);
      step();
      id_valid = 1'b0;
      e = sb_q.pop_front();
      exp_red = (e.kind == 2'b11) || ((e.kind == 2'b10) && e.cond);
      check($sformatf("v%0d_kind", i), kind, e.kind);
      if (e.kind != 2'b11) check($sformatf("v%0d_cond", i), cond, e.cond);
      check($sformatf("v%0d_redirect", i), redirect, exp_red);
      check($sformatf("v%0d_busy", i), busy, exp_red);
      if (e.chk_pc) check($sformatf("v%0d_pc", i), redirect_pc, e.pc);
      fcnt = flush ? 1 : 0;
      for (int c = 0; c < 20 && flush; c++) begin
         step();
         if (flush) fcnt++;
      end
      check($sformatf("v%0d_flush_len", i), fcnt, exp_red ? FC : 0);
      step();
      check($sformatf("v%0d_idle_kind", i), kind, 2'b00);
      check($sformatf("v%0d_idle_busy", i), busy, 1'b0);
   endtask

   initial begin
      int  fcnt;
      logic done;

      vecs[0]  = mk(32'h1022_FFFE, 32'd5, 32'd5, 32'h0000_0100, 2'b10, 1'b1, 1'b1, 32'h0000_00F8);
      vecs[1]  = mk(32'h1022_0010, 32'd5, 32'd6, 32'h0000_0200, 2'b10, 1'b0, 1'b1, 32'h0000_0240);
      vecs[2]  = mk(32'h1422_0010, 32'd7, 32'd7, 32'h0000_0200, 2'b10, 1'b0, 1'b1, 32'h0000_0240);
      vecs[3]  = mk(32'h1422_0004, 32'd1, 32'd2, 32'h0000_0300, 2'b10, 1'b1, 1'b1, 32'h0000_0310);
      vecs[4]  = mk(32'h1820_0008, 32'd0, 32'd9, 32'h0000_0400, 2'b10, 1'b1, 1'b1, 32'h0000_0420);
      vecs[5]  = mk(32'h1820_0008, 32'd5, 32'd0, 32'h0000_0400, 2'b10, 1'b0, 1'b1, 32'h0000_0420);
      vecs[6]  = mk(32'h1820_0008, 32'h8000_0000, 32'd0, 32'h0000_0400, 2'b10, 1'b1, 1'b1, 32'h0000_0420);
      vecs[7]  = mk(32'h1C20_0008, 32'd1, 32'd0, 32'h0000_0400, 2'b10, 1'b1, 1'b1, 32'h0000_0420);
      vecs[8]  = mk(32'h1C20_0008, 32'd0, 32'd0, 32'h0000_0400, 2'b10, 1'b0, 1'b1, 32'h0000_0420);
      vecs[9]  = mk(32'h1C20_0008, 32'hFFFF_FFFF, 32'd0, 32'h0000_0400, 2'b10, 1'b0, 1'b1, 32'h0000_0420);
      vecs[10] = mk(32'h0420_0008, 32'h8000_0000, 32'd0, 32'h0000_0400, 2'b10, 1'b1, 1'b1, 32'h0000_0420);
      vecs[11] = mk(32'h0421_0008, 32'h8000_0000, 32'd0, 32'h0000_0400, 2'b10, 1'b0, 1'b1, 32'h0000_0420);
      vecs[12] = mk(32'h0421_0008, 32'd0, 32'd0, 32'h0000_0400, 2'b10, 1'b1, 1'b1, 32'h0000_0420);
      vecs[13] = mk(32'h0422_0008, 32'h8000_0000, 32'd0, 32'h0000_0400, 2'b00, 1'b0, 1'b0, 32'h0);
      vecs[14] = mk(32'h0800_0040, 32'd0, 32'd0, 32'h1000_0004, 2'b11, 1'b0, 1'b1, 32'h1000_0100);
      vecs[15] = mk(32'h0C00_0040, 32'd0, 32'd0, 32'hF000_0004, 2'b11, 1'b0, 1'b1, 32'hF000_0100);
      vecs[16] = mk(32'h0020_0008, 32'hDEAD_BEE0, 32'd0, 32'h0000_0500, 2'b11, 1'b0, 1'b1, 32'hDEAD_BEE0);
      vecs[17] = mk(32'h0022_0020, 32'd3, 32'd3, 32'h0000_0600, 2'b00, 1'b0, 1'b0, 32'h0);
      vecs[18] = mk(32'h2022_0005, 32'd3, 32'd3, 32'h0000_0600, 2'b00, 1'b0, 1'b0, 32'h0);

      // Reset held two cycles with a taken BEQ on the input
      rst = 1'b1;
      stall = 1'b0;
      drive(vecs[0]);
      step();
      step();
      rst = 1'b0;
      id_valid = 1'b0;
      check("rst_kind", kind, 2'b00);
      check("rst_redirect", redirect, 1'b0);
      check("rst_flush", flush, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_pc", redirect_pc, 32'h0);
      step();
      check("post_rst_kind", kind, 2'b00);
      check("post_rst_pc", redirect_pc, 32'h0);

      for (int i = 0; i < 19; i++) apply_vec(i);
      check("sb_empty", sb_q.size(), 0);

      // Taken BEQ with valid BEQs presented throughout the flush window
      drive(vecs[0]);
      step();
      check("fl_kind", kind, 2'b10);
      check("fl_redirect", redirect, 1'b1);
      check("fl_pc", redirect_pc, 32'h0000_00F8);
      fcnt = flush ? 1 : 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         step();
         if (flush) begin
            fcnt++;
            check("fl_squash_kind", kind, 2'b00);
            check("fl_squash_redirect", redirect, 1'b0);
            check("fl_squash_busy", busy, 1'b1);
         end else begin
            done = 1'b1;
         end
      end
      id_valid = 1'b0;
      check("fl_len", fcnt, FC);
      check("fl_after_kind", kind, 2'b00);
      step();
      check("fl_ignored_kind", kind, 2'b00);
      check("fl_ignored_flush", flush, 1'b0);

      // BNE not taken followed back-to-back by J
      drive(vecs[2]);
      step();
      drive(mk(32'h0800_0040, 32'd0, 32'd0, 32'h1000_0004, 2'b11, 1'b0, 1'b1, 32'h1000_0100));
      check("bb_bne_kind", kind, 2'b10);
      check("bb_bne_cond", cond, 1'b0);
      check("bb_bne_flush", flush, 1'b0);
      step();
      id_valid = 1'b0;
      check("bb_j_kind", kind, 2'b11);
      check("bb_j_redirect", redirect, 1'b1);
      check("bb_j_pc", redirect_pc, 32'h1000_0100);
      for (int c = 0; c < 20 && flush; c++) step();
      check("bb_j_drained", flush, 1'b0);
      step();

      // JR held in EXEC by a 3-cycle stall
      drive(vecs[16]);
      step();
      id_valid = 1'b0;
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         check("st_redirect", redirect, 1'b1);
         check("st_pc", redirect_pc, 32'hDEAD_BEE0);
         check("st_flush", flush, 1'b1);
         step();
      end
      check("st_last_kind", kind, 2'b11);
      stall = 1'b0;
      fcnt = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         step();
         if (flush) fcnt++;
         else done = 1'b1;
      end
      check("st_flush_rest", fcnt, FC - 1);
      check("st_busy_end", busy, 1'b0);

`ifdef BRANCH_STATS_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      apply_vec(0);
      apply_vec(3);
      apply_vec(16);
      apply_vec(1);
      apply_vec(2);
      check("stat_total", br_total, 32'd5);
      check("stat_taken", br_taken, 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("stat_total_rst", br_total, 32'd0);
      check("stat_taken_rst", br_taken, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
